regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
// Owns the single write port (wen/addrW/dataW) of the 32x32 register file. After reset it clears
// every register by sequencing 32 zero-writes, then shares the port between the pipeline writeback
// stage (priority) and a debug write requester, with a bounded wait so debug is never starved.
// Sits between the writeback stage / debug unit and the register file.
// PARAMETERS
// NREGS        32  number of registers cleared during INIT (power of 2)
// AW           5   register address width, log2(NREGS)
// DW           32  data width
// DBG_MAXWAIT  8   consecutive cycles a valid debug request may lose before wb is stalled
// PORTS
// clk        in   1   clock, all state on posedge
// rst        in   1   synchronous, active-high reset
// wb_wen     in   1   writeback write request (no handshake; held stable while wb_stall=1)
// wb_addr    in   AW  writeback destination register
// wb_data    in   DW  writeback data
// dbg_valid  in   1   debug write request valid
// dbg_addr   in   AW  debug destination register
// dbg_data   in   DW  debug write data
// dbg_ready  out  1   debug request accepted this cycle (combinational from state and wb_*)
// wb_stall   out  1   registered; pipeline must hold wb_* and not advance
// init_done  out  1   registered; 1 once clearing finished
// rf_wen     out  1   registered write enable to register file
// rf_addrW   out  AW  registered write address
// rf_dataW   out  DW  registered write data
// BEHAVIOUR
// - Reset: state=INIT, cnt=0, starve=0, rf_wen=0, rf_addrW=0, rf_dataW=0, wb_stall=1, init_done=0.
// - Latency: a granted request appears on rf_* the cycle after grant (1 cycle); rf_wen held 1 cycle.
// - INIT: each cycle drive rf_wen=1, rf_addrW=cnt, rf_dataW=0, cnt++. After the cnt=NREGS-1 write is
//   issued -> RUN; init_done=1 and wb_stall=0 from that cycle on. INIT lasts exactly NREGS cycles.
//   In INIT dbg_ready=0, wb_* ignored.
// - RUN, grant rules evaluated each cycle:
//   * wb_wen=1 and wb_addr!=0: grant wb; if dbg_valid, starve++ (saturates at DBG_MAXWAIT).
//   * else if dbg_valid: dbg_ready=1, grant dbg, starve=0.
//   * else rf_wen=0 next cycle.
//   * starve reaching DBG_MAXWAIT (with dbg_valid still 1) -> next state DBG_FORCE, wb_stall=1.
// - DBG_FORCE: one cycle; dbg_ready=1, grant dbg, wb_* ignored (pipeline holds it), starve=0;
//   -> RUN with wb_stall=0; the held wb request is granted on the following cycle.
// - If dbg_valid drops before grant, starve=0 (no force).
// - x0: any write with addr=0 (wb or dbg) is dropped: rf_wen=0; the dbg handshake still completes.
//   wb_wen with wb_addr=0 counts as no wb request (dbg may take the slot). INIT still writes x0=0.
// - Width: cnt is AW+1 bits; rf_addrW=cnt[AW-1:0]; no wrap beyond NREGS-1.
// - rst asserted mid-INIT or mid-RUN: all state back to reset values next edge; INIT restarts at
//   x0; any ungranted debug request is not acknowledged.
// - dbg_valid/dbg_addr/dbg_data must be held stable until dbg_ready=1.
// TESTING
// - Reset, idle 40 cycles -> rf_wen=1 for exactly 32 cycles, addrs 0..31, data 0; init_done rises
//   at cycle 32; wb_stall falls same cycle.
// - After init, wb_wen=1 addr=5 data=0xDEADBEEF -> next cycle rf_wen=1, rf_addrW=5, rf_dataW=0xDEADBEEF.
// - Same cycle wb addr=3 and dbg addr=7 -> wb written first; dbg_ready=1 on first cycle wb_wen=0,
//   addr 7 written one cycle later.
// - wb_wen=1 continuously, dbg_valid held from cycle t -> wb_stall=1 at t+8, dbg_ready=1 in that
//   cycle, rf_addrW=dbg_addr at t+9, wb_stall=0 at t+9, held wb write at t+10.
// - dbg write addr=0 data=0x1234 -> dbg_ready=1, rf_wen stays 0; wb addr=0 with dbg addr=9 -> dbg granted.
// - rst pulsed at INIT cnt=17 -> INIT restarts, 32 fresh clears from x0, init_done=0 until complete.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback/debug request and register-file write port bundle
interface regfile_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wb_wen;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          dbg_valid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          dbg_ready;
  logic          init_done;
  logic          rf_wen;
  logic [AW-1:0] rf_addrW;
  logic [DW-1:0] rf_dataW;

  modport master (
    output wb_wen, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
    input  wb_stall, dbg_ready, init_done, rf_wen, rf_addrW, rf_dataW
  );

  modport slave (
    input  wb_wen, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
    output wb_stall, dbg_ready, init_done, rf_wen, rf_addrW, rf_dataW
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register file write-port owner: clear-on-reset, wb priority, bounded debug wait
module regfile_wr_arbiter #(
  parameter int NREGS       = 32,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int DBG_MAXWAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam int SW = $clog2(DBG_MAXWAIT + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FORCE} state_t;

  state_t        state, state_n;
  logic [AW:0]   cnt, cnt_n;
  logic [SW-1:0] starve, starve_n;
  logic          rf_wen_q, rf_wen_n;
  logic [AW-1:0] rf_addr_q, rf_addr_n;
  logic [DW-1:0] rf_data_q, rf_data_n;
  logic          wb_stall_q;
  logic          init_done_q;
  logic          dbg_ready_c;
  logic          wb_req;

  // A write to x0 is not a real request, so debug may use that slot.
  assign wb_req = bus.wb_wen && (bus.wb_addr != '0);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    starve_n    = starve;
    rf_wen_n    = 1'b0;
    rf_addr_n   = rf_addr_q;
    rf_data_n   = rf_data_q;
    dbg_ready_c = 1'b0;
    case (state)
      S_INIT: begin
        rf_wen_n  = 1'b1;
        rf_addr_n = cnt[AW-1:0];
        rf_data_n = '0;
        cnt_n     = cnt + 1'b1;
        if (cnt == (AW+1)'(NREGS - 1)) state_n = S_RUN;
      end
      S_RUN: begin
        if (wb_req) begin
          rf_wen_n  = 1'b1;
          rf_addr_n = bus.wb_addr;
          rf_data_n = bus.wb_data;
          if (bus.dbg_valid) begin
            starve_n = (starve == SW'(DBG_MAXWAIT)) ? starve : starve + 1'b1;
            if (starve_n == SW'(DBG_MAXWAIT)) state_n = S_FORCE;
          end else begin
            starve_n = '0;
          end
        end else if (bus.dbg_valid) begin
          dbg_ready_c = 1'b1;
          rf_wen_n    = (bus.dbg_addr != '0);
          rf_addr_n   = bus.dbg_addr;
          rf_data_n   = bus.dbg_data;
          starve_n    = '0;
        end else begin
          starve_n = '0;
        end
      end
      S_FORCE: begin
        // The pipeline is stalled this cycle; its held request is served next cycle.
        if (bus.dbg_valid) begin
          dbg_ready_c = 1'b1;
          rf_wen_n    = (bus.dbg_addr != '0);
          rf_addr_n   = bus.dbg_addr;
          rf_data_n   = bus.dbg_data;
        end
        starve_n = '0;
        state_n  = S_RUN;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      cnt         <= '0;
      starve      <= '0;
      rf_wen_q    <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      wb_stall_q  <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      starve      <= starve_n;
      rf_wen_q    <= rf_wen_n;
      rf_addr_q   <= rf_addr_n;
      rf_data_q   <= rf_data_n;
      wb_stall_q  <= (state_n != S_RUN);
      init_done_q <= (state_n != S_INIT);
    end
  end

  assign bus.dbg_ready = dbg_ready_c;
  assign bus.wb_stall  = wb_stall_q;
  assign bus.init_done = init_done_q;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_addrW  = rf_addr_q;
  assign bus.rf_dataW  = rf_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter_if #(.AW(5), .DW(32)) bus ();

  regfile_wr_arbiter #(.NREGS(32), .AW(5), .DW(32), .DBG_MAXWAIT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.wb_wen = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h11;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_data = 32'h22;
    tick; tick;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %0h exp 0", bus.rf_wen); end
    checks++; if (bus.rf_addrW !== 5'd0) begin errors++; $display("FAIL reset_rf_addrW got %0h exp 0", bus.rf_addrW); end
    checks++; if (bus.rf_dataW !== 32'd0) begin errors++; $display("FAIL reset_rf_dataW got %0h exp 0", bus.rf_dataW); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %0h exp 0", bus.init_done); end
    checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL reset_wb_stall got %0h exp 1", bus.wb_stall); end
    checks++; if (bus.dbg_ready !== 1'b0) begin errors++; $display("FAIL reset_dbg_ready got %0h exp 0", bus.dbg_ready); end
    bus.wb_wen = 1'b0;
    bus.dbg_valid = 1'b0;
  endtask

  task automatic test_init;
    int nwr;
    nwr = 0;
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (bus.rf_wen === 1'b1) nwr++;
      checks++; if (bus.rf_wen !== (i <= 32)) begin errors++; $display("FAIL init_rf_wen cycle %0d got %0h exp %0h", i, bus.rf_wen, (i <= 32)); end
      if (i <= 32) begin
        checks++; if (bus.rf_addrW !== 5'(i - 1)) begin errors++; $display("FAIL init_addr cycle %0d got %0d exp %0d", i, bus.rf_addrW, i - 1); end
        checks++; if (bus.rf_dataW !== 32'd0) begin errors++; $display("FAIL init_data cycle %0d got %0h exp 0", i, bus.rf_dataW); end
      end
      checks++; if (bus.init_done !== (i >= 32)) begin errors++; $display("FAIL init_done cycle %0d got %0h exp %0h", i, bus.init_done, (i >= 32)); end
      checks++; if (bus.wb_stall !== (i < 32)) begin errors++; $display("FAIL init_wb_stall cycle %0d got %0h exp %0h", i, bus.wb_stall, (i < 32)); end
    end
    checks++; if (nwr != 32) begin errors++; $display("FAIL init_write_count got %0d exp 32", nwr); end
  endtask

  task automatic test_wb_write;
    bus.wb_wen = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    tick;
    bus.wb_wen = 1'b0;
    checks++; if (bus.rf_wen !== 1'b1) begin errors++; $display("FAIL wb_rf_wen got %0h exp 1", bus.rf_wen); end
    checks++; if (bus.rf_addrW !== 5'd5) begin errors++; $display("FAIL wb_rf_addrW got %0d exp 5", bus.rf_addrW); end
    checks++; if (bus.rf_dataW !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_rf_dataW got %0h exp deadbeef", bus.rf_dataW); end
    tick;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL wb_idle_rf_wen got %0h exp 0", bus.rf_wen); end
  endtask

  task automatic test_priority;
    bus.wb_wen = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_data = 32'h77;
    #1;
    checks++; if (bus.dbg_ready !== 1'b0) begin errors++; $display("FAIL prio_dbg_ready_lose got %0h exp 0", bus.dbg_ready); end
    tick;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addrW !== 5'd3) begin errors++; $display("FAIL prio_wb_first got wen %0h addr %0d exp wen 1 addr 3", bus.rf_wen, bus.rf_addrW); end
    bus.wb_wen = 1'b0;
    #1;
    checks++; if (bus.dbg_ready !== 1'b1) begin errors++; $display("FAIL prio_dbg_ready_win got %0h exp 1", bus.dbg_ready); end
    tick;
    bus.dbg_valid = 1'b0;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addrW !== 5'd7 || bus.rf_dataW !== 32'h77) begin
      errors++; $display("FAIL prio_dbg_write got wen %0h addr %0d data %0h exp wen 1 addr 7 data 77", bus.rf_wen, bus.rf_addrW, bus.rf_dataW);
    end
    tick;
  endtask

  task automatic test_starve;
    logic [31:0] exp_data;
    logic [4:0]  exp_addr;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd12; bus.dbg_data = 32'hDB;
    bus.wb_wen = 1'b1; bus.wb_addr = 5'd10;
    for (int k = 0; k <= 9; k++) begin
      bus.wb_data = 32'h100 + 32'((k < 9) ? k : 8);
      #1;
      checks++; if (bus.wb_stall !== (k == 8)) begin errors++; $display("FAIL starve_wb_stall k=%0d got %0h exp %0h", k, bus.wb_stall, (k == 8)); end
      checks++; if (bus.dbg_ready !== (k == 8)) begin errors++; $display("FAIL starve_dbg_ready k=%0d got %0h exp %0h", k, bus.dbg_ready, (k == 8)); end
      tick;
      if (k == 8) bus.dbg_valid = 1'b0;
      exp_addr = (k == 8) ? 5'd12 : 5'd10;
      exp_data = (k == 8) ? 32'hDB : ((k == 9) ? 32'h108 : 32'h100 + 32'(k));
      checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addrW !== exp_addr || bus.rf_dataW !== exp_data) begin
        errors++; $display("FAIL starve_rf k=%0d got wen %0h addr %0d data %0h exp wen 1 addr %0d data %0h", k, bus.rf_wen, bus.rf_addrW, bus.rf_dataW, exp_addr, exp_data);
      end
    end
    bus.wb_wen = 1'b0;
    tick;
  endtask

  task automatic test_x0;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_data = 32'h1234;
    #1;
    checks++; if (bus.dbg_ready !== 1'b1) begin errors++; $display("FAIL x0_dbg_ready got %0h exp 1", bus.dbg_ready); end
    tick;
    bus.dbg_valid = 1'b0;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL x0_dbg_dropped got %0h exp 0", bus.rf_wen); end
    bus.wb_wen = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_data = 32'h99;
    #1;
    checks++; if (bus.dbg_ready !== 1'b1) begin errors++; $display("FAIL x0_wb_yields got %0h exp 1", bus.dbg_ready); end
    tick;
    bus.dbg_valid = 1'b0;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addrW !== 5'd9 || bus.rf_dataW !== 32'h99) begin
      errors++; $display("FAIL x0_dbg_write got wen %0h addr %0d data %0h exp wen 1 addr 9 data 99", bus.rf_wen, bus.rf_addrW, bus.rf_dataW);
    end
    tick;
    bus.wb_wen = 1'b0;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wb_dropped got %0h exp 0", bus.rf_wen); end
  endtask

  task automatic test_rst_mid_init;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    repeat (17) tick;
    checks++; if (bus.rf_addrW !== 5'd16) begin errors++; $display("FAIL midinit_progress got %0d exp 16", bus.rf_addrW); end
    rst = 1'b1;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd4; bus.dbg_data = 32'h44;
    tick;
    checks++; if (bus.rf_wen !== 1'b0 || bus.rf_addrW !== 5'd0) begin errors++; $display("FAIL midinit_reset_rf got wen %0h addr %0d exp wen 0 addr 0", bus.rf_wen, bus.rf_addrW); end
    checks++; if (bus.init_done !== 1'b0 || bus.wb_stall !== 1'b1) begin errors++; $display("FAIL midinit_reset_flags got done %0h stall %0h exp done 0 stall 1", bus.init_done, bus.wb_stall); end
    checks++; if (bus.dbg_ready !== 1'b0) begin errors++; $display("FAIL midinit_dbg_ready got %0h exp 0", bus.dbg_ready); end
    bus.dbg_valid = 1'b0;
    test_init();
  endtask

  initial begin
    bus.wb_wen = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.dbg_valid = 1'b0; bus.dbg_addr = '0; bus.dbg_data = '0;
    test_reset();
    test_init();
    test_wb_write();
    test_priority();
    test_starve();
    test_x0();
    test_rst_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
